// File: rtl/sim_mem_port_arbiter.sv
// Two-requester round-robin front end for a fixed-latency memory port.
// Reads are tracked by a {valid,id} tag shift register so each response is routed back to its issuer.

module sim_mem_port_arbiter_cnt (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        acc,
  input  logic        is_wr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (acc) begin
      if (is_wr) wr_cnt <= wr_cnt + 32'd1;
      else       rd_cnt <= rd_cnt + 32'd1;
    end
  end
endmodule

module sim_mem_port_arbiter #(
  parameter int MEM_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG = 22,
  parameter int READ_LATENCY  = 50
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [MEM_DEPTH_LOG-1:0] s0_addr,
  input  logic [MEM_WIDTH/8-1:0]   s0_we,
  input  logic [MEM_WIDTH-1:0]     s0_wdata,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [MEM_DEPTH_LOG-1:0] s1_addr,
  input  logic [MEM_WIDTH/8-1:0]   s1_we,
  input  logic [MEM_WIDTH-1:0]     s1_wdata,
  output logic                     r0_valid,
  output logic [MEM_WIDTH-1:0]     r0_data,
  output logic                     r1_valid,
  output logic [MEM_WIDTH-1:0]     r1_data,
  output logic                     mem_en,
  output logic                     mem_rst,
  output logic [MEM_DEPTH_LOG-1:0] mem_addr,
  output logic [MEM_WIDTH/8-1:0]   mem_we,
  output logic [MEM_WIDTH-1:0]     mem_din,
  input  logic [MEM_WIDTH-1:0]     mem_dout,
  output logic                     idle,
  output logic [31:0]              rd_cnt0,
  output logic [31:0]              rd_cnt1,
  output logic [31:0]              wr_cnt0,
  output logic [31:0]              wr_cnt1
);
  localparam int BW = MEM_WIDTH / 8;
  localparam int L  = READ_LATENCY;

  logic                          prio;
  logic [1:0]                    req, rdy, gnt;
  logic [1:0][MEM_DEPTH_LOG-1:0] addr;
  logic [1:0][BW-1:0]            we;
  logic [1:0][MEM_WIDTH-1:0]     wdata;
  logic                          gid, rd_gnt;
  logic [L-1:0]                  vld_pipe, id_pipe;
  logic [1:0][31:0]              rd_cnt, wr_cnt;

  assign req   = {s1_valid, s0_valid};
  assign addr  = {s1_addr, s0_addr};
  assign we    = {s1_we, s0_we};
  assign wdata = {s1_wdata, s0_wdata};

  // Ready means "would win if it asked": only the other side's valid and prio matter.
  assign rdy[0] = ap_rst_n & (~s1_valid | ~prio);
  assign rdy[1] = ap_rst_n & (~s0_valid |  prio);
  assign gnt    = req & rdy;
  assign gid    = gnt[1];
  assign s0_ready = rdy[0];
  assign s1_ready = rdy[1];

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_we   = '0;
    mem_din  = '0;
    if (|gnt) begin
      mem_en   = 1'b1;
      mem_addr = addr[gid];
      mem_we   = we[gid];
      mem_din  = wdata[gid];
    end
  end

  assign rd_gnt  = (|gnt) & ~(|we[gid]);
  assign mem_rst = ~ap_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) prio <= 1'b0;
    else if (|gnt) prio <= ~gid;
  end

  // Tag pipeline: stage L-1 lines up with the memory's read data.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= rd_gnt;
      id_pipe[0]  <= gid;
      for (int i = 1; i < L; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign r0_valid = ap_rst_n & vld_pipe[L-1] & ~id_pipe[L-1];
  assign r1_valid = ap_rst_n & vld_pipe[L-1] &  id_pipe[L-1];
  assign r0_data  = mem_dout;
  assign r1_data  = mem_dout;

  assign idle = ~ap_rst_n | (~(|vld_pipe) & ~s0_valid & ~s1_valid);

  for (genvar k = 0; k < 2; k++) begin : g_cnt
    sim_mem_port_arbiter_cnt u_cnt (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .acc      (gnt[k]),
      .is_wr    (|we[k]),
      .rd_cnt   (rd_cnt[k]),
      .wr_cnt   (wr_cnt[k])
    );
  end

  assign rd_cnt0 = rd_cnt[0];
  assign rd_cnt1 = rd_cnt[1];
  assign wr_cnt0 = wr_cnt[0];
  assign wr_cnt1 = wr_cnt[1];
endmodule
